// File: rtl/ras_ckpt_pkg.sv
// ras_ckpt_pkg: shared sizing and checkpoint type for the return address stack.
//   RAS_DEPTH         default entry count
//   RAS_TARGET_WIDTH  default stored target width (low PC bits)
//   LOG_RAS_DEPTH     pointer width derived from RAS_DEPTH
//   ras_ckpt_t        checkpoint carried in the branch info: {ptr, count[, top]}
// Optional feature macro: RAS_TOP_REPAIR_EN adds the repaired top target to ras_ckpt_t.
package ras_ckpt_pkg;

  localparam int RAS_DEPTH        = 8;
  localparam int RAS_TARGET_WIDTH = 12;
  localparam int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH);

  typedef struct packed {
    logic [LOG_RAS_DEPTH-1:0]    ptr;
    logic [LOG_RAS_DEPTH:0]      count;
`ifdef RAS_TOP_REPAIR_EN
    logic [RAS_TARGET_WIDTH-1:0] top;
`endif
  } ras_ckpt_t;

endpackage

// File: rtl/ras_ckpt.sv
// ras_ckpt: circular return address stack with checkpoint/restore.
//   Overflow silently overwrites the oldest entry; a pop on an empty stack is
//   flagged on pop_underflow and changes nothing. Restore has priority over
//   push/pop and takes effect in one cycle.
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   push_valid/push_target   call: push a return target
//   pop_valid                return: pop the top entry
//   top_valid/top_target     current prediction (combinational from state)
//   pop_underflow            pop requested on empty stack with nothing else
//   ckpt_ptr/ckpt_count      current state, for snapshotting
//   restore_valid/_ptr/_count  mispredict recovery
//   ckpt_top/restore_top     only with RAS_TOP_REPAIR_EN
// Optional feature macro: RAS_TOP_REPAIR_EN (restore also rewrites entry[restore_ptr]).
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int RAS_DEPTH        = ras_ckpt_pkg::RAS_DEPTH,
  parameter int RAS_TARGET_WIDTH = ras_ckpt_pkg::RAS_TARGET_WIDTH,
  parameter int LOG_RAS_DEPTH    = $clog2(RAS_DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  output logic                        top_valid,
  output logic [RAS_TARGET_WIDTH-1:0] top_target,
  output logic                        pop_underflow,
  output logic [LOG_RAS_DEPTH-1:0]    ckpt_ptr,
  output logic [LOG_RAS_DEPTH:0]      ckpt_count,
`ifdef RAS_TOP_REPAIR_EN
  output logic [RAS_TARGET_WIDTH-1:0] ckpt_top,
  input  logic [RAS_TARGET_WIDTH-1:0] restore_top,
`endif
  input  logic                        restore_valid,
  input  logic [LOG_RAS_DEPTH-1:0]    restore_ptr,
  input  logic [LOG_RAS_DEPTH:0]      restore_count
);

  localparam logic [LOG_RAS_DEPTH-1:0] PTR_LAST  = LOG_RAS_DEPTH'(RAS_DEPTH - 1);
  localparam logic [LOG_RAS_DEPTH-1:0] PTR_ONE   = LOG_RAS_DEPTH'(1);
  localparam logic [LOG_RAS_DEPTH:0]   CNT_FULL  = (LOG_RAS_DEPTH + 1)'(RAS_DEPTH);
  localparam logic [LOG_RAS_DEPTH:0]   CNT_ONE   = (LOG_RAS_DEPTH + 1)'(1);
  localparam logic [LOG_RAS_DEPTH:0]   CNT_ZERO  = (LOG_RAS_DEPTH + 1)'(0);

  logic [LOG_RAS_DEPTH-1:0]    r_ptr;
  logic [LOG_RAS_DEPTH:0]      r_count;
  logic [RAS_TARGET_WIDTH-1:0] r_entries [RAS_DEPTH];

  logic [LOG_RAS_DEPTH-1:0]    w_ptr_nxt;
  logic [LOG_RAS_DEPTH:0]      w_count_nxt;
  logic                        w_wr_req;
  logic                        w_wr_en;
  logic [LOG_RAS_DEPTH-1:0]    w_wr_idx;
  logic [RAS_TARGET_WIDTH-1:0] w_wr_data;
  logic [RAS_TARGET_WIDTH-1:0] w_top;
  logic                        w_empty;

  // Explicit wrap so non-power-of-2 depths never step past the last entry.
  function automatic logic [LOG_RAS_DEPTH-1:0] ptr_inc(input logic [LOG_RAS_DEPTH-1:0] p);
    if (p == PTR_LAST) ptr_inc = '0;
    else               ptr_inc = p + PTR_ONE;
  endfunction

  function automatic logic [LOG_RAS_DEPTH-1:0] ptr_dec(input logic [LOG_RAS_DEPTH-1:0] p);
    if (p == '0) ptr_dec = PTR_LAST;
    else         ptr_dec = p - PTR_ONE;
  endfunction

  assign w_empty = (r_count == CNT_ZERO);

  // Read port: guarded so an out-of-range pointer can never index past the array.
  always_comb begin
    w_top = '0;
    if (r_ptr <= PTR_LAST) w_top = r_entries[r_ptr];
    else                   w_top = '0;
  end

  assign top_valid     = !w_empty;
  assign top_target    = w_top;
  assign pop_underflow = pop_valid && w_empty && !push_valid && !restore_valid;
  assign ckpt_ptr      = r_ptr;
  assign ckpt_count    = r_count;
`ifdef RAS_TOP_REPAIR_EN
  assign ckpt_top      = w_top;
`endif

  // Next-state and single write-port selection; restore overrides push/pop.
  always_comb begin
    w_ptr_nxt   = r_ptr;
    w_count_nxt = r_count;
    w_wr_req    = 1'b0;
    w_wr_idx    = r_ptr;
    w_wr_data   = push_target;
    if (restore_valid) begin
      w_ptr_nxt   = restore_ptr;
      w_count_nxt = restore_count;
`ifdef RAS_TOP_REPAIR_EN
      w_wr_req    = 1'b1;
      w_wr_idx    = restore_ptr;
      w_wr_data   = restore_top;
`endif
    end else if (push_valid && pop_valid) begin
      // Tail call: replace the top in place.
      w_wr_req = 1'b1;
      w_wr_idx = r_ptr;
      if (w_empty) w_count_nxt = CNT_ONE;
      else         w_count_nxt = r_count;
    end else if (push_valid) begin
      w_ptr_nxt = ptr_inc(r_ptr);
      w_wr_req  = 1'b1;
      w_wr_idx  = ptr_inc(r_ptr);
      if (r_count == CNT_FULL) w_count_nxt = r_count;
      else                     w_count_nxt = r_count + CNT_ONE;
    end else if (pop_valid) begin
      if (!w_empty) begin
        w_ptr_nxt   = ptr_dec(r_ptr);
        w_count_nxt = r_count - CNT_ONE;
      end else begin
        w_ptr_nxt   = r_ptr;
        w_count_nxt = r_count;
      end
    end else begin
      w_ptr_nxt   = r_ptr;
      w_count_nxt = r_count;
    end
  end

  assign w_wr_en = w_wr_req && (w_wr_idx <= PTR_LAST);

  // State and storage registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_entries[i] <= '0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_count <= w_count_nxt;
      if (w_wr_en) r_entries[w_wr_idx] <= w_wr_data;
    end
  end

  // A restored checkpoint must describe a reachable state.
  a_restore_legal: assert property (@(posedge CLK) disable iff (RST)
    restore_valid |-> (restore_count <= CNT_FULL) && (restore_ptr <= PTR_LAST));

endmodule

// File: tb/tb_ras_ckpt.sv
// tb_ras_ckpt: drives a depth-8 and a depth-6 ras_ckpt with directed scenarios
// and randomized traffic, checking both against an array-based stack model.
// Honours RAS_TOP_REPAIR_EN when defined.
module tb_ras_ckpt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_valid = 1'b0;
  logic [11:0] push_target = 12'h000;
  logic        pop_valid = 1'b0;
  logic        restore_valid = 1'b0;
  logic [2:0]  rp8 = 3'd0, rp6 = 3'd0;
  logic [3:0]  rc8 = 4'd0, rc6 = 4'd0;
  logic [11:0] restore_top = 12'h000;

  logic        tv8, tv6, uf8, uf6;
  logic [11:0] tt8, tt6;
  logic [2:0]  cp8, cp6;
  logic [3:0]  cc8, cc6;
`ifdef RAS_TOP_REPAIR_EN
  logic [11:0] ct8, ct6;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per instance, plain arrays with modulo pointer arithmetic.
  int          dep [2] = '{8, 6};
  int          m_ptr [2];
  int          m_cnt [2];
  logic [11:0] m_mem [2][8];
  logic        last_uf8;

  always #5 clk = ~clk;

  ras_ckpt #(.RAS_DEPTH(8), .RAS_TARGET_WIDTH(12)) u_dut8 (
    .CLK(clk), .RST(rst), .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid), .top_valid(tv8), .top_target(tt8), .pop_underflow(uf8),
    .ckpt_ptr(cp8), .ckpt_count(cc8),
`ifdef RAS_TOP_REPAIR_EN
    .ckpt_top(ct8), .restore_top(restore_top),
`endif
    .restore_valid(restore_valid), .restore_ptr(rp8), .restore_count(rc8));

  ras_ckpt #(.RAS_DEPTH(6), .RAS_TARGET_WIDTH(12)) u_dut6 (
    .CLK(clk), .RST(rst), .push_valid(push_valid), .push_target(push_target),
    .pop_valid(pop_valid), .top_valid(tv6), .top_target(tt6), .pop_underflow(uf6),
    .ckpt_ptr(cp6), .ckpt_count(cc6),
`ifdef RAS_TOP_REPAIR_EN
    .ckpt_top(ct6), .restore_top(restore_top),
`endif
    .restore_valid(restore_valid), .restore_ptr(rp6), .restore_count(rc6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ptr[k] = 0;
      m_cnt[k] = 0;
      for (int e = 0; e < 8; e++) m_mem[k][e] = 12'h000;
    end
  endtask

  // Compare every output of both instances against the model (pre-update).
  task automatic check_model();
    for (int k = 0; k < 2; k++) begin
      logic        exp_uf;
      logic [11:0] exp_top;
      exp_top = m_mem[k][m_ptr[k]];
      exp_uf  = pop_valid && (m_cnt[k] == 0) && !push_valid && !restore_valid;
      if (k == 0) begin
        chk("d8.top_valid", 32'(tv8), 32'(m_cnt[0] != 0));
        chk("d8.top_target", 32'(tt8), 32'(exp_top));
        chk("d8.underflow", 32'(uf8), 32'(exp_uf));
        chk("d8.ptr", 32'(cp8), 32'(m_ptr[0]));
        chk("d8.count", 32'(cc8), 32'(m_cnt[0]));
`ifdef RAS_TOP_REPAIR_EN
        chk("d8.ckpt_top", 32'(ct8), 32'(exp_top));
`endif
      end else begin
        chk("d6.top_valid", 32'(tv6), 32'(m_cnt[1] != 0));
        chk("d6.top_target", 32'(tt6), 32'(exp_top));
        chk("d6.underflow", 32'(uf6), 32'(exp_uf));
        chk("d6.ptr", 32'(cp6), 32'(m_ptr[1]));
        chk("d6.count", 32'(cc6), 32'(m_cnt[1]));
`ifdef RAS_TOP_REPAIR_EN
        chk("d6.ckpt_top", 32'(ct6), 32'(exp_top));
`endif
      end
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int d;
      int rp;
      int rc;
      d  = dep[k];
      rp = (k == 0) ? int'(rp8) : int'(rp6);
      rc = (k == 0) ? int'(rc8) : int'(rc6);
      if (restore_valid) begin
        m_ptr[k] = rp;
        m_cnt[k] = rc;
`ifdef RAS_TOP_REPAIR_EN
        m_mem[k][rp] = restore_top;
`endif
      end else if (push_valid && pop_valid) begin
        m_mem[k][m_ptr[k]] = push_target;
        if (m_cnt[k] == 0) m_cnt[k] = 1;
      end else if (push_valid) begin
        m_ptr[k] = (m_ptr[k] + 1) % d;
        m_mem[k][m_ptr[k]] = push_target;
        m_cnt[k] = (m_cnt[k] + 1 > d) ? d : m_cnt[k] + 1;
      end else if (pop_valid && m_cnt[k] > 0) begin
        m_ptr[k] = (m_ptr[k] + d - 1) % d;
        m_cnt[k] = m_cnt[k] - 1;
      end
    end
  endtask

  // One command cycle: drive, check pre-update outputs at negedge, advance model.
  task automatic cycle(input logic pv, input logic [11:0] pt, input logic ppv,
                       input logic rv, input logic [2:0] p8, input logic [3:0] c8,
                       input logic [2:0] p6, input logic [3:0] c6, input logic [11:0] rt);
    push_valid    = pv;
    push_target   = pt;
    pop_valid     = ppv;
    restore_valid = rv;
    rp8 = p8; rc8 = c8; rp6 = p6; rc6 = c6;
    restore_top   = rt;
    @(negedge clk);
    check_model();
    last_uf8 = uf8;
    @(posedge clk);
    model_step();
    #1;
    push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
  endtask

  task automatic op(input logic pv, input logic [11:0] pt, input logic ppv);
    cycle(pv, pt, ppv, 1'b0, 3'd0, 4'd0, 3'd0, 4'd0, 12'h000);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push_valid = 1'b0; pop_valid = 1'b0; restore_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [2:0] s_ptr;
    logic [3:0] s_cnt;
    int         exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};

    // Reset and idle.
    do_reset();
    chk("rst.top_valid", 32'(tv8), 32'd0);
    chk("rst.top_target", 32'(tt8), 32'd0);
    chk("rst.underflow", 32'(uf8), 32'd0);
    chk("rst.ptr", 32'(cp8), 32'd0);
    chk("rst.count", 32'(cc8), 32'd0);
    op(1'b0, 12'h000, 1'b0);

    // Pop on empty flags underflow and changes nothing.
    op(1'b0, 12'h000, 1'b1);
    chk("uf.flag", 32'(last_uf8), 32'd1);
    chk("uf.ptr", 32'(cp8), 32'd0);
    chk("uf.count", 32'(cc8), 32'd0);
    op(1'b0, 12'h000, 1'b0);

    // LIFO order.
    op(1'b1, 12'h100, 1'b0);
    op(1'b1, 12'h200, 1'b0);
    op(1'b1, 12'h300, 1'b0);
    chk("lifo.top", 32'(tt8), 32'h300);
    chk("lifo.ptr", 32'(cp8), 32'd3);
    chk("lifo.count", 32'(cc8), 32'd3);
    chk("lifo.pop1", 32'(tt8), 32'h300); op(1'b0, 12'h000, 1'b1);
    chk("lifo.pop2", 32'(tt8), 32'h200); op(1'b0, 12'h000, 1'b1);
    chk("lifo.pop3", 32'(tt8), 32'h100); op(1'b0, 12'h000, 1'b1);
    chk("lifo.empty", 32'(tv8), 32'd0);

    // Overflow: depth 8 saturates and wraps.
    do_reset();
    for (int i = 1; i <= 10; i++) op(1'b1, 12'(i), 1'b0);
    chk("ovf.count", 32'(cc8), 32'd8);
    chk("ovf.ptr", 32'(cp8), 32'd2);
    chk("ovf.count6", 32'(cc6), 32'd6);
    for (int i = 10; i >= 3; i--) begin
      chk("ovf.pop", 32'(tt8), 32'(i));
      op(1'b0, 12'h000, 1'b1);
    end
    op(1'b0, 12'h000, 1'b1);
    chk("ovf.underflow", 32'(last_uf8), 32'd1);

    // Non-power-of-2 wrap on depth 6.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      op(1'b1, 12'(16 + i), 1'b0);
      chk("d6.wrap_ptr", 32'(cp6), 32'(exp_seq[i]));
    end
    chk("d6.wrap_top", 32'(tt6), 32'd22);

    // Tail-call replace.
    do_reset();
    op(1'b1, 12'h005, 1'b0);
    op(1'b1, 12'h00A, 1'b0);
    op(1'b1, 12'h00B, 1'b1);
    chk("tc.count", 32'(cc8), 32'd2);
    chk("tc.ptr", 32'(cp8), 32'd2);
    chk("tc.top", 32'(tt8), 32'h00B);
    do_reset();
    op(1'b1, 12'h00C, 1'b1);
    chk("tc0.count", 32'(cc8), 32'd1);
    chk("tc0.ptr", 32'(cp8), 32'd0);
    chk("tc0.top", 32'(tt8), 32'h00C);

    // Checkpoint, wrong-path pop + push, restore with a competing push.
    do_reset();
    op(1'b1, 12'h100, 1'b0);
    op(1'b1, 12'h200, 1'b0);
    s_ptr = cp8;
    s_cnt = cc8;
    chk("ck.snap_ptr", 32'(s_ptr), 32'd2);
    chk("ck.snap_cnt", 32'(s_cnt), 32'd2);
    op(1'b0, 12'h000, 1'b1);
    op(1'b1, 12'hEEE, 1'b0);
    cycle(1'b1, 12'h777, 1'b0, 1'b1, s_ptr, s_cnt, s_ptr, s_cnt, 12'h200);
    chk("ck.count", 32'(cc8), 32'd2);
    chk("ck.ptr", 32'(cp8), 32'd2);
`ifdef RAS_TOP_REPAIR_EN
    chk("ck.top", 32'(tt8), 32'h200);
`else
    chk("ck.top", 32'(tt8), 32'hEEE);
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [11:0] t;
      r = int'($urandom_range(0, 9));
      t = 12'($urandom);
      case (r)
        0, 1, 2, 3: op(1'b1, t, 1'b0);
        4, 5, 6:    op(1'b0, t, 1'b1);
        7:          op(1'b1, t, 1'b1);
        8:          cycle(1'($urandom), t, 1'($urandom), 1'b1,
                          3'($urandom_range(0, 7)), 4'($urandom_range(0, 8)),
                          3'($urandom_range(0, 5)), 4'($urandom_range(0, 6)),
                          12'($urandom));
        default:    op(1'b0, t, 1'b0);
      endcase
    end
    op(1'b0, 12'h000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
